// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  // Byte distance between sequential instructions.
  localparam int PC_STEP = 4;

  // Low address bits forced to zero on the memory request.
  localparam int IMEM_ALIGN_BITS = 2;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Pair of saturating event counters for the fetch stage.
// Latency: one cycle from increment strobe to updated count.
// Backpressure: none; strobes are sampled every cycle.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_fetch_inc        one accepted, non-killed instruction transfer
//   i_stall_inc        one cycle waiting on instruction memory
//   o_fetched/o_stall  current counts, stick at all-ones
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch_inc,
  input  logic        i_stall_inc,
  output logic [31:0] o_fetched,
  output logic [31:0] o_stall
);

  logic [31:0] r_fetched;
  logic [31:0] r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetched <= '0;
      r_stall   <= '0;
    end else begin
      if (i_fetch_inc && (r_fetched != '1)) r_fetched <= r_fetched + 32'd1;
      if (i_stall_inc && (r_stall != '1))   r_stall   <= r_stall + 32'd1;
    end
  end

  assign o_fetched = r_fetched;
  assign o_stall   = r_stall;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, result presented to decode.
// Latency: response in cycle N -> if_valid in cycle N+1; PC advance is same-cycle.
// Backpressure: if_ready low holds the instruction in HOLD and issues no new request.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   pc_in / pc_load / pc_next         PC register read and load interface
//   imem_read / imem_address          memory request (word aligned, held until response)
//   imem_resp / imem_rdata            memory response pulse and data
//   if_valid / if_ready               decode handshake
//   if_pc / if_instr                  presented instruction and its unmodified PC
//   redirect / redirect_target        control-flow redirect
//   perf_fetched / perf_stall         counters, present only with FETCH_PERF_CNT_EN
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] pc_in,
  output logic             pc_load,
  output logic [width-1:0] pc_next,
  output logic             imem_read,
  output logic [width-1:0] imem_address,
  input  logic             imem_resp,
  input  logic [width-1:0] imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [width-1:0] if_pc,
  output logic [width-1:0] if_instr,
  input  logic             redirect,
  input  logic [width-1:0] redirect_target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stall
`endif
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [width-1:0] r_req_addr;
  logic             r_req_latched;
  logic [width-1:0] r_if_pc;
  logic [width-1:0] r_if_instr;

  logic             w_pc_load;
  logic [width-1:0] w_pc_next;
  logic             w_capture;
  logic [width-1:0] w_pc_aligned;
  logic [width-1:0] w_pc_seq;

  assign w_pc_aligned = {pc_in[width-1:IMEM_ALIGN_BITS], {IMEM_ALIGN_BITS{1'b0}}};
  assign w_pc_seq     = pc_in + width'(PC_STEP);

  always_comb begin
    w_state_next = r_state;
    w_pc_load    = 1'b0;
    w_pc_next    = '0;
    w_capture    = 1'b0;

    case (r_state)
      IDLE: begin
        w_state_next = REQ;
        if (redirect) begin
          w_pc_load = 1'b1;
          w_pc_next = redirect_target;
        end
      end
      REQ: begin
        if (redirect) begin
          // A response in the same cycle belongs to the killed path: drop it
          // and start over at the target; otherwise wait out the request.
          w_pc_load    = 1'b1;
          w_pc_next    = redirect_target;
          w_state_next = imem_resp ? REQ : DRAIN;
        end else if (imem_resp) begin
          w_capture    = 1'b1;
          w_pc_load    = 1'b1;
          w_pc_next    = w_pc_seq;
          w_state_next = HOLD;
        end
      end
      DRAIN: begin
        if (redirect) begin
          w_pc_load = 1'b1;
          w_pc_next = redirect_target;
        end
        if (imem_resp) w_state_next = REQ;
      end
      HOLD: begin
        // Redirect wins over a same-cycle if_ready: the instruction is killed.
        if (redirect) begin
          w_pc_load    = 1'b1;
          w_pc_next    = redirect_target;
          w_state_next = REQ;
        end else if (if_ready) begin
          w_state_next = REQ;
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (rst) begin
      w_state_next = IDLE;
      w_pc_load    = 1'b0;
      w_pc_next    = '0;
      w_capture    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_req_addr    <= '0;
      r_req_latched <= 1'b0;
      r_if_pc       <= '0;
      r_if_instr    <= '0;
    end else begin
      r_state <= w_state_next;
      // The PC register is updated at the edge that enters REQ, so the
      // address is taken from pc_in during the first REQ cycle and frozen
      // afterwards; DRAIN keeps presenting it while pc_in moves on.
      if ((r_state == REQ) && !r_req_latched) r_req_addr <= w_pc_aligned;
      r_req_latched <= (r_state == REQ) && (w_state_next == REQ) && !imem_resp;
      if (w_capture) begin
        r_if_pc    <= pc_in;
        r_if_instr <= imem_rdata;
      end
    end
  end

  assign pc_load      = w_pc_load;
  assign pc_next      = w_pc_next;
  assign imem_read    = !rst && ((r_state == REQ) || (r_state == DRAIN));
  assign imem_address = ((r_state == REQ) && !r_req_latched) ? w_pc_aligned : r_req_addr;
  assign if_valid     = !rst && (r_state == HOLD);
  assign if_pc        = r_if_pc;
  assign if_instr     = r_if_instr;

`ifdef FETCH_PERF_CNT_EN
  logic w_fetch_inc;
  logic w_stall_inc;

  assign w_fetch_inc = if_valid && if_ready && !redirect;
  assign w_stall_inc = ((r_state == REQ) || (r_state == DRAIN)) && !imem_resp;

  fetch_perf_cnt u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_fetch_inc (w_fetch_inc),
    .i_stall_inc (w_stall_inc),
    .o_fetched   (perf_fetched),
    .o_stall     (perf_stall)
  );
`else
  // Counters not built.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect;
  logic [31:0] redirect_target;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.width(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .pc_load         (pc_load),
    .pc_next         (pc_next),
    .imem_read       (imem_read),
    .imem_address    (imem_address),
    .imem_resp       (imem_resp),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .redirect        (redirect),
    .redirect_target (redirect_target)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stall      (perf_stall)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0013 : (a ^ 32'h0C0D_E000);
  endfunction

  // PC register model
  logic [31:0] pc_reg;
  always @(posedge clk) begin
    if (rst)          pc_reg <= 32'h8000_0000;
    else if (pc_load) pc_reg <= pc_next;
  end
  assign pc_in = pc_reg;

  // Instruction memory model: responds in the mem_lat-th cycle of a request
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  always @(posedge clk) begin
    #2;
    imem_resp  = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (rst) begin
      mem_cnt = 0;
    end else if (imem_read) begin
      if (mem_cnt == 0) mem_addr = imem_address;
      else              check("imem_addr_stable", imem_address, mem_addr);
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        imem_resp  = 1'b1;
        imem_rdata = instr_of(imem_address);
        mem_cnt    = 0;
      end
    end else begin
      if (mem_cnt != 0) check("imem_read_held", 32'(imem_read), 32'd1);
      mem_cnt = 0;
    end
  end

  // Scoreboard of instructions expected to reach decode
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];
  int   n_xfer = 0;

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] addr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr_of(addr);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && if_valid && if_ready && !redirect) begin
      n_xfer++;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_xfer: got pc %h, expected no transfer", if_pc);
      end else begin
        e = sb.pop_front();
        check("xfer_pc", if_pc, e.pc);
        check("xfer_instr", if_instr, e.instr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      @(negedge clk);
      if (if_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: if_valid=0 after 40 cycles, expected 1", name);
    end
  endtask

  task automatic accept();
    int x0;
    step();
    x0 = n_xfer;
    if_ready = 1'b1;
    @(negedge clk);
    step();
    if_ready = 1'b0;
    @(negedge clk);
    check("accept_count", 32'(n_xfer), 32'(x0 + 1));
    check("accept_valid_drop", 32'(if_valid), 32'd0);
  endtask

  task automatic redir(input logic [31:0] tgt);
    step();
    redirect        = 1'b1;
    redirect_target = tgt;
    @(negedge clk);
    check("redir_load", 32'(pc_load), 32'd1);
    check("redir_next", pc_next, tgt);
  endtask

  typedef struct {
    logic [31:0] tgt;
    int          lat;
    int          rdy;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    vecs[0] = '{32'h8000_0040, 1, 0, 32'h8000_0040, 32'h8000_0044};
    vecs[1] = '{32'h8000_0006, 2, 5, 32'h8000_0004, 32'h8000_000A};
    vecs[2] = '{32'hFFFF_FFFC, 3, 1, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h0000_1233, 1, 2, 32'h0000_1230, 32'h0000_1237};
    vecs[4] = '{32'h7FFF_FFFF, 4, 0, 32'h7FFF_FFFC, 32'h8000_0003};

    rst = 1'b1; if_ready = 1'b1; redirect = 1'b0; redirect_target = '0;
    imem_resp = 1'b0; imem_rdata = '0;

    // Reset state and basic fetch
    step(); step();
    @(negedge clk);
    check("rst_imem_read", 32'(imem_read), 32'd0);
    check("rst_pc_load", 32'(pc_load), 32'd0);
    check("rst_pc_next", pc_next, 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
    check("rst_perf_stall", perf_stall, 32'd0);
`endif
    step(); rst = 1'b0;
    @(negedge clk);
    check("idle_imem_read", 32'(imem_read), 32'd0);
    push_exp(32'h8000_0000, 32'h8000_0000);
    step(); @(negedge clk);
    check("basic_read", 32'(imem_read), 32'd1);
    check("basic_addr", imem_address, 32'h8000_0000);
    check("basic_load", 32'(pc_load), 32'd1);
    check("basic_next", pc_next, 32'h8000_0004);
    step(); @(negedge clk);
    check("basic_valid", 32'(if_valid), 32'd1);
    check("basic_if_pc", if_pc, 32'h8000_0000);
    check("basic_if_instr", if_instr, 32'h0000_0013);
    step(); if_ready = 1'b0;
    @(negedge clk);
    check("basic_valid_drop", 32'(if_valid), 32'd0);
    wait_valid("basic_next_hold");

    // Table: redirect from HOLD, fetch, backpressure, accept
    foreach (vecs[i]) begin
      mem_lat = vecs[i].lat;
      redir(vecs[i].tgt);
      push_exp(vecs[i].tgt, vecs[i].exp_addr);
      done = 1'b0;
      for (int k = 0; k < 20; k++) begin
        step(); @(negedge clk);
        check("vec_read", 32'(imem_read), 32'd1);
        check("vec_addr", imem_address, vecs[i].exp_addr);
        check("vec_no_valid", 32'(if_valid), 32'd0);
        if (imem_resp) begin
          check("vec_load", 32'(pc_load), 32'd1);
          check("vec_next", pc_next, vecs[i].exp_next);
          done = 1'b1;
          break;
        end else begin
          check("vec_wait_no_load", 32'(pc_load), 32'd0);
        end
      end
      if (!done) begin
        n_checks++; n_errors++;
        $display("FAIL vec_resp: no response in 20 cycles, expected one");
      end
      step(); @(negedge clk);
      check("vec_valid", 32'(if_valid), 32'd1);
      check("vec_if_pc", if_pc, vecs[i].tgt);
      for (int r = 0; r < vecs[i].rdy; r++) begin
        step(); @(negedge clk);
        check("bp_valid", 32'(if_valid), 32'd1);
        check("bp_if_pc", if_pc, vecs[i].tgt);
        check("bp_if_instr", if_instr, instr_of(vecs[i].exp_addr));
        check("bp_imem_read", 32'(imem_read), 32'd0);
        check("bp_pc_load", 32'(pc_load), 32'd0);
      end
      accept();
      wait_valid("vec_next_hold");
    end

    // Redirect one cycle into a 3-cycle request
    mem_lat = 3;
    redir(32'h8000_0004);
    step(); @(negedge clk);
    check("rq_addr0", imem_address, 32'h8000_0004);
    step(); redirect = 1'b1; redirect_target = 32'h8000_0100;
    @(negedge clk);
    check("rq_redir_load", 32'(pc_load), 32'd1);
    check("rq_redir_next", pc_next, 32'h8000_0100);
    step(); @(negedge clk);
    check("drain_read", 32'(imem_read), 32'd1);
    check("drain_addr", imem_address, 32'h8000_0004);
    check("drain_no_load", 32'(pc_load), 32'd0);
    check("drain_no_valid", 32'(if_valid), 32'd0);
    push_exp(32'h8000_0100, 32'h8000_0100);
    step(); @(negedge clk);
    check("after_drain_addr", imem_address, 32'h8000_0100);
    check("after_drain_no_valid", 32'(if_valid), 32'd0);
    wait_valid("rq_hold");
    check("rq_if_pc", if_pc, 32'h8000_0100);
    accept();
    wait_valid("rq_next_hold");

    // Two redirects while draining: latest target wins
    mem_lat = 4;
    redir(32'h8000_0010);
    step(); @(negedge clk);
    step(); redirect = 1'b1; redirect_target = 32'h8000_0500;
    @(negedge clk);
    step(); redirect = 1'b1; redirect_target = 32'h8000_0600;
    @(negedge clk);
    check("drain_redir_load", 32'(pc_load), 32'd1);
    check("drain_redir_next", pc_next, 32'h8000_0600);
    check("drain_redir_addr", imem_address, 32'h8000_0010);
    step(); @(negedge clk);
    check("drain2_no_load", 32'(pc_load), 32'd0);
    push_exp(32'h8000_0600, 32'h8000_0600);
    step(); @(negedge clk);
    check("latest_addr", imem_address, 32'h8000_0600);
    wait_valid("latest_hold");
    accept();
    wait_valid("latest_next_hold");

    // Redirect coincident with the response
    mem_lat = 1;
    redir(32'h8000_0200);
    step(); redirect = 1'b1; redirect_target = 32'h8000_0300;
    @(negedge clk);
    check("coinc_load", 32'(pc_load), 32'd1);
    check("coinc_next", pc_next, 32'h8000_0300);
    push_exp(32'h8000_0300, 32'h8000_0300);
    step(); @(negedge clk);
    check("coinc_no_valid", 32'(if_valid), 32'd0);
    check("coinc_req_read", 32'(imem_read), 32'd1);
    check("coinc_req_addr", imem_address, 32'h8000_0300);
    wait_valid("coinc_hold");
    accept();
    wait_valid("coinc_next_hold");

    // Reset in the middle of a request
    mem_lat = 4;
    redir(32'h8000_0700);
    step(); @(negedge clk);
    step(); rst = 1'b1;
    @(negedge clk);
    step(); @(negedge clk);
    check("mrst_imem_read", 32'(imem_read), 32'd0);
    check("mrst_if_valid", 32'(if_valid), 32'd0);
    check("mrst_pc_load", 32'(pc_load), 32'd0);
    check("mrst_if_pc", if_pc, 32'd0);
    check("mrst_if_instr", if_instr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("mrst_perf_fetched", perf_fetched, 32'd0);
    check("mrst_perf_stall", perf_stall, 32'd0);
`endif

    // Four 2-cycle fetches, the fourth killed by a redirect with if_ready high
    step(); rst = 1'b0; mem_lat = 2; if_ready = 1'b1;
    push_exp(32'h8000_0000, 32'h8000_0000);
    push_exp(32'h8000_0004, 32'h8000_0004);
    push_exp(32'h8000_0008, 32'h8000_0008);
    begin
      int x0;
      x0 = n_xfer;
      done = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (n_xfer >= x0 + 3) begin
          done = 1'b1;
          break;
        end
      end
      if (!done) begin
        n_checks++; n_errors++;
        $display("FAIL perf_xfers: %0d transfers, expected 3", n_xfer - x0);
      end
    end
    step(); if_ready = 1'b0;
    wait_valid("perf_hold4");
    check("perf_hold4_pc", if_pc, 32'h8000_000C);
    step(); redirect = 1'b1; redirect_target = 32'h8000_0800; if_ready = 1'b1;
    @(negedge clk);
    check("kill_load", 32'(pc_load), 32'd1);
    check("kill_next", pc_next, 32'h8000_0800);
    push_exp(32'h8000_0800, 32'h8000_0800);
    step(); if_ready = 1'b0;
    @(negedge clk);
    check("kill_valid_drop", 32'(if_valid), 32'd0);
    wait_valid("kill_hold");
    check("kill_if_pc", if_pc, 32'h8000_0800);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'd3);
    check("perf_stall", perf_stall, 32'd5);
`endif
    accept();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
